decode_xp: RTL and testbench
============================

DECODE_XP -- requirements
Module: decode_xp

Interface
REQ-001 Parameter XLEN, default 32: datapath width, minimum 32.
REQ-002 Parameter NREG, default 32: architectural register count, power of two, maximum 32; register NREG-1 reads as zero.
REQ-003 Parameter NBYP, default 3: number of bypass sources (index 0 = youngest stage).
REQ-004 Ports, one per line as name, direction, width, meaning:
- clk  in  1  clock, single clock domain
- rst  in  1  reset, synchronous, active-high
- pc_in  in  XLEN  PC+4 from fetch
- ir_in  in  32  fetched instruction
- flush  in  1  kill the instruction being latched into decode
- irq  in  1  external interrupt request, level
- byp_rc  in  NBYP*5  Rc of each bypass stage
- byp_data  in  NBYP*XLEN  bypass value per stage
- byp_wr  in  NBYP  stage writes the register file
- byp_ld  in  NBYP  stage holds a load whose value is not ready
- rf_we / rf_wa / rf_wd  in  1/5/XLEN  register file write port
- a_next, b_next, d_next  out  XLEN  operand A, operand B, store data
- pc_next, ir_next  out  XLEN/32  to execute stage
- j_addr, br_addr  out  XLEN  jump target and branch target
- op_jmp, op_beq, op_bne, zr  out  1  branch controls
- stall  out  1  hold fetch and decode
- exc_ill, exc_irq  out  1  exception injected this cycle

Function
REQ-005 The decode register (ir_d, pc_d) SHALL load ir_in/pc_in on each cycle that stall=0; it SHALL hold while stall=1.
REQ-006 If flush=1 and stall=0, ir_d SHALL load INST_NOP; flush SHALL be ignored while stall=1.
REQ-007 Fields: opcode=ir_d[31:26], Rc=[25:21], Ra=[20:16], Rb=[15:11], lit=[15:0]. Register indices SHALL be truncated to log2(NREG) bits.
REQ-008 Legal opcodes: LD 011000, ST 011001, JMP 011011, BEQ 011100, BNE 011101, LDR 011111, plus the ALU opcode sets 100000-100001, 100100-100110, 101000-101110, 110000-110001, 110100-110110, and 111000-111110. All other opcodes are illegal.
REQ-009 Read port 2 address SHALL be Rc for ST, otherwise Rb.
REQ-010 Operand forwarding: for each read port, the lowest bypass index i with byp_wr[i]=1 and byp_rc[i]=address SHALL supply the value, else the register file value. Address NREG-1 never matches and reads zero.
REQ-011 The register file SHALL be write-before-read: a same-cycle rf_we to the read address returns rf_wd.
REQ-012 stall SHALL be 1 when a port that is used by the instruction has a bypass match at index i with byp_ld[i]=1.
- Port 1 is used by every opcode.
- Port 2 is used only by no-literal ALU opcodes and ST.
REQ-013 While stall=1, ir_next SHALL be INST_NOP.
REQ-014 Operand and target outputs:
- a_next = br_addr for LDR, otherwise forwarded port 1.
- b_next = sign-extended lit for LD, ST and literal ALU opcodes, otherwise forwarded port 2.
- d_next = forwarded port 2.
- br_addr = pc_d + (sign-extended lit << 2), modulo 2^XLEN.
- j_addr = forwarded port 1.
- zr = 1 when forwarded port 1 is zero.
REQ-015 irq_pend SHALL set on irq=1 when pc_d[XLEN-1]=0 (user mode), and SHALL clear when an interrupt is injected.
REQ-016 Injection priority applies only when stall=0 and ir_d != INST_NOP:
- First, irq_pend: ir_next=INST_BNE_EXCEPT and exc_irq=1.
- Otherwise, an illegal opcode: ir_next=INST_BNE_EXCEPT and exc_ill=1.
- In both cases pc_next=pc_d.
REQ-017 After an injection, the next ir_d SHALL load INST_NOP regardless of ir_in (a one-cycle shadow kill).
REQ-018 If an injection and a stall would coincide, stall SHALL win; the injection is deferred and irq_pend is retained.
REQ-019 Otherwise ir_next=ir_d and pc_next=pc_d. op_jmp, op_beq and op_bne SHALL be 0 whenever ir_next is not ir_d.

Reset
REQ-020 While rst=1 at a clk edge, the block SHALL set ir_d=INST_NOP, pc_d=0, irq_pend=0 and shadow-kill=0; the register file contents are not reset.
REQ-021 During rst=1, stall=0, exc_ill=0, exc_irq=0 and ir_next=INST_NOP.
REQ-022 Asserting rst mid-stall or mid-injection SHALL abort that operation with no pending state.

Verification
REQ-023 ADDC R1,R31,5 followed by ADD R2,R1,R1, with stage-0 byp_rc=1, byp_wr=1, byp_data=5 -> a_next=5, b_next=5, stall=0.
REQ-024 byp_rc[0]=3, byp_ld[0]=1, with decode holding SUB R4,R3,R2 -> stall=1, ir_next=INST_NOP, and ir_d held. After byp_ld drops -> ir_next=SUB.
REQ-025 ir_d opcode 000000 with pc_d=0x100 -> ir_next=INST_BNE_EXCEPT, pc_next=0x100, exc_ill=1; the next cycle shows INST_NOP.
REQ-026 irq pulses for 1 cycle with pc_d=0x200 (user mode), decode holding a legal ADD -> exc_irq=1 on the next unstalled non-NOP instruction. The same pulse with pc_d=0x8000_0200 -> no injection.
REQ-027 BEQ with lit=0xFFFF, pc_d=0x40, forwarded port 1=0 -> br_addr=0x3C, zr=1, op_beq=1.
REQ-028 Parameter sweep XLEN=64, NREG=16, NBYP=4 -> an R15 read returns 0, and bypass index 0 wins over index 3 on the same Rc.

Source files
------------

// File: rtl/decode_xp.sv
// Decode stage: operand fetch with forwarding, load-use stall, and
// exception/interrupt injection into the execute instruction stream.
module decode_xp #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NBYP = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [XLEN-1:0]      pc_in,
    input  logic [31:0]          ir_in,
    input  logic                 flush,
    input  logic                 irq,
    input  logic [NBYP*5-1:0]    byp_rc,
    input  logic [NBYP*XLEN-1:0] byp_data,
    input  logic [NBYP-1:0]      byp_wr,
    input  logic [NBYP-1:0]      byp_ld,
    input  logic                 rf_we,
    input  logic [4:0]           rf_wa,
    input  logic [XLEN-1:0]      rf_wd,
    output logic [XLEN-1:0]      a_next,
    output logic [XLEN-1:0]      b_next,
    output logic [XLEN-1:0]      d_next,
    output logic [XLEN-1:0]      pc_next,
    output logic [31:0]          ir_next,
    output logic [XLEN-1:0]      j_addr,
    output logic [XLEN-1:0]      br_addr,
    output logic                 op_jmp,
    output logic                 op_beq,
    output logic                 op_bne,
    output logic                 zr,
    output logic                 stall,
    output logic                 exc_ill,
    output logic                 exc_irq
);

    localparam int AW = $clog2(NREG);
    localparam logic [AW-1:0] ZR = AW'(NREG - 1);

    // NOP = ADD R31,R31,R31; exception = BNE R31 -> XP (R30), lit 0
    localparam logic [31:0] INST_NOP        = 32'h83FF_F800;
    localparam logic [31:0] INST_BNE_EXCEPT = 32'h77DF_0000;

    localparam logic [5:0] OP_LD  = 6'b011000;
    localparam logic [5:0] OP_ST  = 6'b011001;
    localparam logic [5:0] OP_JMP = 6'b011011;
    localparam logic [5:0] OP_BEQ = 6'b011100;
    localparam logic [5:0] OP_BNE = 6'b011101;
    localparam logic [5:0] OP_LDR = 6'b011111;

    logic [31:0]     ir_d;
    logic [XLEN-1:0] pc_d;
    logic            irq_pend;
    logic [XLEN-1:0] rf [NREG];

    logic [5:0]      op;
    logic [AW-1:0]   ra, rb, rc, addr2;
    logic            is_ld, is_st, is_jmp, is_beq, is_bne, is_ldr;
    logic            is_alu, is_alu_l, is_alu_r, legal, use2;
    logic [XLEN-1:0] rf1, rf2, fwd1, fwd2, sext;
    logic            ld1, ld2;
    logic            live, inj_irq, inj_ill, inject, pass;

    assign op = ir_d[31:26];
    assign rc = ir_d[21 +: AW];
    assign ra = ir_d[16 +: AW];
    assign rb = ir_d[11 +: AW];

    assign is_ld  = op == OP_LD;
    assign is_st  = op == OP_ST;
    assign is_jmp = op == OP_JMP;
    assign is_beq = op == OP_BEQ;
    assign is_bne = op == OP_BNE;
    assign is_ldr = op == OP_LDR;

    // ALU rows 10xxxx (register) and 11xxxx (literal) share one column map
    assign is_alu = op[5] &&
        (op[3:0] inside {4'd0, 4'd1, [4'd4:4'd6], [4'd8:4'd14]});
    assign is_alu_l = is_alu && op[4];
    assign is_alu_r = is_alu && !op[4];
    assign legal = is_ld | is_st | is_jmp | is_beq
                 | is_bne | is_ldr | is_alu;
    assign use2  = is_alu_r | is_st;
    assign addr2 = is_st ? rc : rb;

    always_comb begin
        rf1 = rf[ra];
        rf2 = rf[addr2];
        if (rf_we && rf_wa[AW-1:0] == ra)
            rf1 = rf_wd;
        if (rf_we && rf_wa[AW-1:0] == addr2)
            rf2 = rf_wd;
        if (ra == ZR)
            rf1 = '0;
        if (addr2 == ZR)
            rf2 = '0;
    end

    // walk oldest to youngest so the lowest matching index wins
    always_comb begin
        fwd1 = rf1;
        fwd2 = rf2;
        ld1  = 1'b0;
        ld2  = 1'b0;
        for (int i = NBYP - 1; i >= 0; i--) begin
            if (byp_wr[i] && ra != ZR &&
                byp_rc[i*5 +: AW] == ra) begin
                fwd1 = byp_data[i*XLEN +: XLEN];
                ld1  = byp_ld[i];
            end
            if (byp_wr[i] && addr2 != ZR &&
                byp_rc[i*5 +: AW] == addr2) begin
                fwd2 = byp_data[i*XLEN +: XLEN];
                ld2  = byp_ld[i];
            end
        end
    end

    assign stall   = !rst && (ld1 || (use2 && ld2));
    assign live    = !rst && !stall && ir_d != INST_NOP;
    assign inj_irq = live && irq_pend;
    assign inj_ill = live && !irq_pend && !legal;
    assign inject  = inj_irq | inj_ill;
    assign pass    = !rst && !stall && !inject;

    always_comb begin
        ir_next = ir_d;
        unique case (1'b1)
            rst, stall: ir_next = INST_NOP;
            inject:     ir_next = INST_BNE_EXCEPT;
            default:    ir_next = ir_d;
        endcase
    end

    assign sext    = {{(XLEN-16){ir_d[15]}}, ir_d[15:0]};
    assign br_addr = pc_d + {sext[XLEN-3:0], 2'b00};
    assign a_next  = is_ldr ? br_addr : fwd1;
    assign b_next  = (is_ld || is_st || is_alu_l) ? sext : fwd2;
    assign d_next  = fwd2;
    assign j_addr  = fwd1;
    assign zr      = fwd1 == '0;
    assign pc_next = pc_d;
    assign op_jmp  = pass && is_jmp;
    assign op_beq  = pass && is_beq;
    assign op_bne  = pass && is_bne;
    assign exc_ill = inj_ill;
    assign exc_irq = inj_irq;

    always_ff @(posedge clk) begin
        if (rst) begin
            ir_d     <= INST_NOP;
            pc_d     <= '0;
            irq_pend <= 1'b0;
        end else begin
            if (!stall) begin
                pc_d <= pc_in;
                // an injection kills the instruction right behind it
                ir_d <= (flush || inject) ? INST_NOP : ir_in;
            end
            if (inj_irq)
                irq_pend <= 1'b0;
            else if (irq && !pc_d[XLEN-1])
                irq_pend <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rf_we)
            rf[rf_wa[AW-1:0]] <= rf_wd;
    end

endmodule

// File: tb/tb_decode_xp.sv
// Scoreboard bench for decode_xp: default instance plus a
// 64-bit / 16-register / 4-bypass instance.
module tb_decode_xp;

    localparam logic [31:0] NOP = 32'h83FF_F800;
    localparam logic [31:0] BNX = 32'h77DF_0000;
    localparam logic [5:0] ADD  = 6'b100000;
    localparam logic [5:0] SUB  = 6'b100001;
    localparam logic [5:0] ADDC = 6'b110000;
    localparam logic [5:0] ST   = 6'b011001;
    localparam logic [5:0] JMP  = 6'b011011;
    localparam logic [5:0] BEQ  = 6'b011100;
    localparam logic [5:0] BNE  = 6'b011101;
    localparam logic [5:0] LDR  = 6'b011111;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] pc_in, ir_in, rf_wd;
    logic        flush, irq, rf_we;
    logic [14:0] byp_rc;
    logic [95:0] byp_data;
    logic [2:0]  byp_wr, byp_ld;
    logic [4:0]  rf_wa;
    logic [31:0] a_next, b_next, d_next, pc_next, ir_next;
    logic [31:0] j_addr, br_addr;
    logic        op_jmp, op_beq, op_bne, zr, stall, exc_ill, exc_irq;

    decode_xp u_dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .ir_in(ir_in),
        .flush(flush), .irq(irq), .byp_rc(byp_rc),
        .byp_data(byp_data), .byp_wr(byp_wr), .byp_ld(byp_ld),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .a_next(a_next), .b_next(b_next), .d_next(d_next),
        .pc_next(pc_next), .ir_next(ir_next), .j_addr(j_addr),
        .br_addr(br_addr), .op_jmp(op_jmp), .op_beq(op_beq),
        .op_bne(op_bne), .zr(zr), .stall(stall),
        .exc_ill(exc_ill), .exc_irq(exc_irq)
    );

    logic [63:0]  pc64, wd64, a64, b64, d64, pcn64, j64, br64;
    logic [31:0]  ir64, irn64;
    logic [19:0]  rc64;
    logic [255:0] bd64;
    logic [3:0]   bw64, bl64;
    logic         we64;
    logic [4:0]   wa64;
    logic         jmp64, beq64, bne64, zr64, st64, ill64, xirq64;

    decode_xp #(.XLEN(64), .NREG(16), .NBYP(4)) u_w (
        .clk(clk), .rst(rst), .pc_in(pc64), .ir_in(ir64),
        .flush(1'b0), .irq(1'b0), .byp_rc(rc64),
        .byp_data(bd64), .byp_wr(bw64), .byp_ld(bl64),
        .rf_we(we64), .rf_wa(wa64), .rf_wd(wd64),
        .a_next(a64), .b_next(b64), .d_next(d64),
        .pc_next(pcn64), .ir_next(irn64), .j_addr(j64),
        .br_addr(br64), .op_jmp(jmp64), .op_beq(beq64),
        .op_bne(bne64), .zr(zr64), .stall(st64),
        .exc_ill(ill64), .exc_irq(xirq64)
    );

    int tests = 0;
    int fails = 0;
    logic [63:0] sb[$];
    logic [63:0] e;

    function automatic logic [31:0] rr(input logic [5:0] o,
        input logic [4:0] c, input logic [4:0] a, input logic [4:0] b);
        return {o, c, a, b, 11'd0};
    endfunction

    function automatic logic [31:0] rl(input logic [5:0] o,
        input logic [4:0] c, input logic [4:0] a, input logic [15:0] l);
        return {o, c, a, l};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_byp();
        byp_rc = '0; byp_data = '0; byp_wr = '0; byp_ld = '0;
    endtask

    task automatic test_reset();
        rst = 1; ir_in = 32'h0; pc_in = 32'h123;
        tick(); tick();
        sb.push_back(64'(NOP)); sb.push_back(64'h0);
        sb.push_back(64'h0); sb.push_back(64'h0);
        e = sb.pop_front(); tests++;
        if (ir_next !== e[31:0]) begin fails++;
            $display("FAIL rst_ir got=%h exp=%h", ir_next, e[31:0]); end
        e = sb.pop_front(); tests++;
        if (pc_next !== e[31:0]) begin fails++;
            $display("FAIL rst_pc got=%h exp=%h", pc_next, e[31:0]); end
        e = sb.pop_front(); tests++;
        if (stall !== e[0]) begin fails++;
            $display("FAIL rst_stall got=%b exp=%b", stall, e[0]); end
        e = sb.pop_front(); tests++;
        if (exc_ill !== e[0]) begin fails++;
            $display("FAIL rst_ill got=%b exp=%b", exc_ill, e[0]); end
        rst = 0; ir_in = NOP; pc_in = 0;
        tick();
    endtask

    task automatic load_rf();
        rf_we = 1;
        rf_wa = 2; rf_wd = 32'h22; tick();
        rf_wa = 3; rf_wd = 32'h33; tick();
        rf_wa = 5; rf_wd = 32'h55; tick();
        rf_we = 0;
    endtask

    task automatic test_bypass();
        ir_in = rl(ADDC, 1, 31, 16'd5); pc_in = 4; tick(); #1;
        sb.push_back(64'h0); sb.push_back(64'h5);
        e = sb.pop_front(); tests++;
        if (a_next !== e[31:0]) begin fails++;
            $display("FAIL addc_a got=%h exp=%h", a_next, e[31:0]); end
        e = sb.pop_front(); tests++;
        if (b_next !== e[31:0]) begin fails++;
            $display("FAIL addc_b got=%h exp=%h", b_next, e[31:0]); end
        ir_in = rr(ADD, 2, 1, 1); pc_in = 8; tick();
        byp_rc = {5'd1, 5'd0, 5'd1}; byp_wr = 3'b101;
        byp_data = {32'h77, 32'h0, 32'h5};
        sb.push_back(64'h5); sb.push_back(64'h5); sb.push_back(64'h0);
        #1;
        e = sb.pop_front(); tests++;
        if (a_next !== e[31:0]) begin fails++;
            $display("FAIL byp_a got=%h exp=%h", a_next, e[31:0]); end
        e = sb.pop_front(); tests++;
        if (b_next !== e[31:0]) begin fails++;
            $display("FAIL byp_b got=%h exp=%h", b_next, e[31:0]); end
        e = sb.pop_front(); tests++;
        if (stall !== e[0]) begin fails++;
            $display("FAIL byp_stall got=%b exp=%b", stall, e[0]); end
        clr_byp();
    endtask

    task automatic test_rf();
        ir_in = rr(ADD, 4, 2, 3); tick();
        rf_we = 1; rf_wa = 2; rf_wd = 32'hABCD;
        sb.push_back(64'hABCD); sb.push_back(64'h33);
        #1;
        e = sb.pop_front(); tests++;
        if (a_next !== e[31:0]) begin fails++;
            $display("FAIL wbr_a got=%h exp=%h", a_next, e[31:0]); end
        e = sb.pop_front(); tests++;
        if (b_next !== e[31:0]) begin fails++;
            $display("FAIL wbr_b got=%h exp=%h", b_next, e[31:0]); end
        rf_we = 0;
        ir_in = rl(ST, 5, 3, 16'h0010); tick();
        sb.push_back(64'h55); sb.push_back(64'h10);
        #1;
        e = sb.pop_front(); tests++;
        if (d_next !== e[31:0]) begin fails++;
            $display("FAIL st_d got=%h exp=%h", d_next, e[31:0]); end
        e = sb.pop_front(); tests++;
        if (b_next !== e[31:0]) begin fails++;
            $display("FAIL st_b got=%h exp=%h", b_next, e[31:0]); end
        byp_rc = 15'd5; byp_wr = 3'b001; byp_ld = 3'b001;
        sb.push_back(64'h1);
        #1;
        e = sb.pop_front(); tests++;
        if (stall !== e[0]) begin fails++;
            $display("FAIL st_rc_stall got=%b exp=%b", stall, e[0]); end
        clr_byp();
        ir_in = rl(ADDC, 4, 3, 16'h1000); tick();
        byp_rc = 15'd2; byp_wr = 3'b001; byp_ld = 3'b001;
        sb.push_back(64'h0); sb.push_back(64'h1000);
        #1;
        e = sb.pop_front(); tests++;
        if (stall !== e[0]) begin fails++;
            $display("FAIL lit_nostall got=%b exp=%b", stall, e[0]); end
        e = sb.pop_front(); tests++;
        if (b_next !== e[31:0]) begin fails++;
            $display("FAIL lit_b got=%h exp=%h", b_next, e[31:0]); end
        clr_byp();
    endtask

    task automatic test_stall();
        ir_in = rr(SUB, 4, 3, 2); pc_in = 32'h30; tick();
        byp_rc = 15'd3; byp_wr = 3'b001; byp_ld = 3'b001;
        byp_data = 96'h99;
        sb.push_back(64'h1); sb.push_back(64'(NOP));
        #1;
        e = sb.pop_front(); tests++;
        if (stall !== e[0]) begin fails++;
            $display("FAIL ld_stall got=%b exp=%b", stall, e[0]); end
        e = sb.pop_front(); tests++;
        if (ir_next !== e[31:0]) begin fails++;
            $display("FAIL ld_stall_ir got=%h exp=%h", ir_next, e[31:0]); end
        ir_in = rr(ADD, 1, 2, 2); pc_in = 32'h34; flush = 1; tick();
        sb.push_back(64'h1); sb.push_back(64'h30);
        e = sb.pop_front(); tests++;
        if (stall !== e[0]) begin fails++;
            $display("FAIL hold_stall got=%b exp=%b", stall, e[0]); end
        e = sb.pop_front(); tests++;
        if (pc_next !== e[31:0]) begin fails++;
            $display("FAIL hold_pc got=%h exp=%h", pc_next, e[31:0]); end
        byp_ld = 3'b000;
        sb.push_back(64'(rr(SUB, 4, 3, 2))); sb.push_back(64'h99);
        sb.push_back(64'h22);
        #1;
        e = sb.pop_front(); tests++;
        if (ir_next !== e[31:0]) begin fails++;
            $display("FAIL release_ir got=%h exp=%h", ir_next, e[31:0]); end
        e = sb.pop_front(); tests++;
        if (a_next !== e[31:0]) begin fails++;
            $display("FAIL release_a got=%h exp=%h", a_next, e[31:0]); end
        e = sb.pop_front(); tests++;
        if (b_next !== e[31:0]) begin fails++;
            $display("FAIL release_b got=%h exp=%h", b_next, e[31:0]); end
        tick();
        flush = 0; clr_byp();
        sb.push_back(64'(NOP));
        #1;
        e = sb.pop_front(); tests++;
        if (ir_next !== e[31:0]) begin fails++;
            $display("FAIL flush_ir got=%h exp=%h", ir_next, e[31:0]); end
    endtask

    task automatic test_illegal();
        ir_in = 32'h0; pc_in = 32'h100; tick();
        ir_in = rr(ADD, 1, 2, 3);
        sb.push_back(64'(BNX)); sb.push_back(64'h100);
        sb.push_back(64'h1); sb.push_back(64'h0);
        #1;
        e = sb.pop_front(); tests++;
        if (ir_next !== e[31:0]) begin fails++;
            $display("FAIL ill_ir got=%h exp=%h", ir_next, e[31:0]); end
        e = sb.pop_front(); tests++;
        if (pc_next !== e[31:0]) begin fails++;
            $display("FAIL ill_pc got=%h exp=%h", pc_next, e[31:0]); end
        e = sb.pop_front(); tests++;
        if (exc_ill !== e[0]) begin fails++;
            $display("FAIL ill_flag got=%b exp=%b", exc_ill, e[0]); end
        e = sb.pop_front(); tests++;
        if (op_bne !== e[0]) begin fails++;
            $display("FAIL ill_bne got=%b exp=%b", op_bne, e[0]); end
        tick();
        sb.push_back(64'(NOP)); sb.push_back(64'h0);
        e = sb.pop_front(); tests++;
        if (ir_next !== e[31:0]) begin fails++;
            $display("FAIL shadow_ir got=%h exp=%h", ir_next, e[31:0]); end
        e = sb.pop_front(); tests++;
        if (exc_ill !== e[0]) begin fails++;
            $display("FAIL shadow_ill got=%b exp=%b", exc_ill, e[0]); end
        tick();
        sb.push_back(64'(rr(ADD, 1, 2, 3)));
        e = sb.pop_front(); tests++;
        if (ir_next !== e[31:0]) begin fails++;
            $display("FAIL after_ir got=%h exp=%h", ir_next, e[31:0]); end
        ir_in = {6'b100010, 26'h0}; tick();
        ir_in = rr(ADD, 1, 2, 3);
        sb.push_back(64'h1);
        #1;
        e = sb.pop_front(); tests++;
        if (exc_ill !== e[0]) begin fails++;
            $display("FAIL gap_ill got=%b exp=%b", exc_ill, e[0]); end
        tick(); tick();
    endtask

    task automatic test_irq();
        pc_in = 32'h200; tick();
        irq = 1;
        sb.push_back(64'h0);
        #1;
        e = sb.pop_front(); tests++;
        if (exc_irq !== e[0]) begin fails++;
            $display("FAIL irq_early got=%b exp=%b", exc_irq, e[0]); end
        tick();
        irq = 0;
        sb.push_back(64'h1); sb.push_back(64'(BNX)); sb.push_back(64'h200);
        #1;
        e = sb.pop_front(); tests++;
        if (exc_irq !== e[0]) begin fails++;
            $display("FAIL irq_flag got=%b exp=%b", exc_irq, e[0]); end
        e = sb.pop_front(); tests++;
        if (ir_next !== e[31:0]) begin fails++;
            $display("FAIL irq_ir got=%h exp=%h", ir_next, e[31:0]); end
        e = sb.pop_front(); tests++;
        if (pc_next !== e[31:0]) begin fails++;
            $display("FAIL irq_pc got=%h exp=%h", pc_next, e[31:0]); end
        tick();
        sb.push_back(64'(NOP));
        e = sb.pop_front(); tests++;
        if (ir_next !== e[31:0]) begin fails++;
            $display("FAIL irq_shadow got=%h exp=%h", ir_next, e[31:0]); end
        tick();
        sb.push_back(64'h0);
        e = sb.pop_front(); tests++;
        if (exc_irq !== e[0]) begin fails++;
            $display("FAIL irq_cleared got=%b exp=%b", exc_irq, e[0]); end
        pc_in = 32'h8000_0200; tick();
        irq = 1; tick();
        irq = 0; tick();
        sb.push_back(64'h0); sb.push_back(64'(rr(ADD, 1, 2, 3)));
        e = sb.pop_front(); tests++;
        if (exc_irq !== e[0]) begin fails++;
            $display("FAIL irq_kernel got=%b exp=%b", exc_irq, e[0]); end
        e = sb.pop_front(); tests++;
        if (ir_next !== e[31:0]) begin fails++;
            $display("FAIL kernel_ir got=%h exp=%h", ir_next, e[31:0]); end
        pc_in = 32'h200; tick();
        irq = 1; tick();
        irq = 0;
        byp_rc = 15'd2; byp_wr = 3'b001; byp_ld = 3'b001;
        sb.push_back(64'h1); sb.push_back(64'h0);
        #1;
        e = sb.pop_front(); tests++;
        if (stall !== e[0]) begin fails++;
            $display("FAIL defer_stall got=%b exp=%b", stall, e[0]); end
        e = sb.pop_front(); tests++;
        if (exc_irq !== e[0]) begin fails++;
            $display("FAIL defer_irq got=%b exp=%b", exc_irq, e[0]); end
        tick();
        clr_byp();
        sb.push_back(64'h1);
        #1;
        e = sb.pop_front(); tests++;
        if (exc_irq !== e[0]) begin fails++;
            $display("FAIL defer_fire got=%b exp=%b", exc_irq, e[0]); end
        tick(); tick();
    endtask

    task automatic test_reset_abort();
        irq = 1; tick();
        irq = 0;
        rst = 1;
        byp_rc = 15'd2; byp_wr = 3'b001; byp_ld = 3'b001;
        sb.push_back(64'h0); sb.push_back(64'h0);
        #1;
        e = sb.pop_front(); tests++;
        if (exc_irq !== e[0]) begin fails++;
            $display("FAIL abort_irq got=%b exp=%b", exc_irq, e[0]); end
        e = sb.pop_front(); tests++;
        if (stall !== e[0]) begin fails++;
            $display("FAIL abort_stall got=%b exp=%b", stall, e[0]); end
        tick();
        rst = 0; clr_byp();
        tick();
        sb.push_back(64'(rr(ADD, 1, 2, 3))); sb.push_back(64'h0);
        e = sb.pop_front(); tests++;
        if (ir_next !== e[31:0]) begin fails++;
            $display("FAIL abort_ir got=%h exp=%h", ir_next, e[31:0]); end
        e = sb.pop_front(); tests++;
        if (exc_irq !== e[0]) begin fails++;
            $display("FAIL abort_pend got=%b exp=%b", exc_irq, e[0]); end
    endtask

    task automatic test_branch();
        ir_in = rl(BEQ, 0, 31, 16'hFFFF); pc_in = 32'h40; tick();
        sb.push_back(64'h3C); sb.push_back(64'h1); sb.push_back(64'h1);
        e = sb.pop_front(); tests++;
        if (br_addr !== e[31:0]) begin fails++;
            $display("FAIL beq_br got=%h exp=%h", br_addr, e[31:0]); end
        e = sb.pop_front(); tests++;
        if (zr !== e[0]) begin fails++;
            $display("FAIL beq_zr got=%b exp=%b", zr, e[0]); end
        e = sb.pop_front(); tests++;
        if (op_beq !== e[0]) begin fails++;
            $display("FAIL beq_op got=%b exp=%b", op_beq, e[0]); end
        ir_in = rl(BNE, 0, 3, 16'h0001); pc_in = 32'h80; tick();
        sb.push_back(64'h84); sb.push_back(64'h0); sb.push_back(64'h1);
        e = sb.pop_front(); tests++;
        if (br_addr !== e[31:0]) begin fails++;
            $display("FAIL bne_br got=%h exp=%h", br_addr, e[31:0]); end
        e = sb.pop_front(); tests++;
        if (zr !== e[0]) begin fails++;
            $display("FAIL bne_zr got=%b exp=%b", zr, e[0]); end
        e = sb.pop_front(); tests++;
        if (op_bne !== e[0]) begin fails++;
            $display("FAIL bne_op got=%b exp=%b", op_bne, e[0]); end
        ir_in = rl(LDR, 7, 31, 16'h0002); pc_in = 32'h10; tick();
        sb.push_back(64'h18);
        e = sb.pop_front(); tests++;
        if (a_next !== e[31:0]) begin fails++;
            $display("FAIL ldr_a got=%h exp=%h", a_next, e[31:0]); end
        ir_in = rl(JMP, 0, 5, 16'h0); tick();
        sb.push_back(64'h55); sb.push_back(64'h1);
        e = sb.pop_front(); tests++;
        if (j_addr !== e[31:0]) begin fails++;
            $display("FAIL jmp_addr got=%h exp=%h", j_addr, e[31:0]); end
        e = sb.pop_front(); tests++;
        if (op_jmp !== e[0]) begin fails++;
            $display("FAIL jmp_op got=%b exp=%b", op_jmp, e[0]); end
    endtask

    task automatic test_param();
        ir64 = rr(ADD, 1, 15, 2); tick();
        we64 = 1; wa64 = 15; wd64 = 64'hDEAD;
        rc64 = {5'd2, 5'd0, 5'd15, 5'd2}; bw64 = 4'b1011;
        bd64 = {64'h3333, 64'h0, 64'hBAD, 64'h1111};
        sb.push_back(64'h0); sb.push_back(64'h1111);
        #1;
        e = sb.pop_front(); tests++;
        if (a64 !== e) begin fails++;
            $display("FAIL w_r15 got=%h exp=%h", a64, e); end
        e = sb.pop_front(); tests++;
        if (b64 !== e) begin fails++;
            $display("FAIL w_byp0 got=%h exp=%h", b64, e); end
        bw64 = 4'b1010;
        sb.push_back(64'h3333);
        #1;
        e = sb.pop_front(); tests++;
        if (b64 !== e) begin fails++;
            $display("FAIL w_byp3 got=%h exp=%h", b64, e); end
        we64 = 0; bw64 = 0;
    endtask

    initial begin
        rst = 1; pc_in = 0; ir_in = NOP; flush = 0; irq = 0;
        rf_we = 0; rf_wa = 0; rf_wd = 0;
        clr_byp();
        pc64 = 0; ir64 = NOP; rc64 = 0; bd64 = 0; bw64 = 0; bl64 = 0;
        we64 = 0; wa64 = 0; wd64 = 0;
        test_reset();
        load_rf();
        test_bypass();
        test_rf();
        test_stall();
        test_illegal();
        test_irq();
        test_reset_abort();
        test_branch();
        test_param();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
